// File: rtl/wb_imem_loader_pkg.sv
// rtl/wb_imem_loader_pkg.sv - shared types and constants for the instruction-SRAM loader
package wb_imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_ACK
  } state_t;

  // Register offsets relative to the CTRL_OFFSET parameter of the top.
  localparam logic [11:0] REG_CTRL   = 12'h000;
  localparam logic [11:0] REG_STATUS = 12'h004;
  localparam logic [11:0] REG_CSUM   = 12'h008;

  localparam int STATUS_ERR_BIT = 16;
  localparam int STATUS_RUN_BIT = 17;
  localparam int WCNT_W         = 16;

endpackage

// File: rtl/wb_imem_loader_if.sv
// rtl/wb_imem_loader_if.sv - Wishbone slave bus bundle for the instruction-SRAM loader
interface wb_imem_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_imem_loader_regs.sv
// rtl/wb_imem_loader_regs.sv - CTRL/STATUS/CSUM storage and read mux
// CSUM accumulator exists only when WB_IMEM_LOADER_CSUM_EN is defined.
module wb_imem_loader_regs
  import wb_imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_we,
  input  logic        hit_ctrl,
  input  logic        hit_status,
  input  logic        hit_csum,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  input  logic        err_set,
  input  logic        wr_done,
  input  logic [31:0] wr_data,
  output logic        run,
  output logic [31:0] rdata
);

  logic [WCNT_W-1:0] wcnt;
  logic              err;
  logic [31:0]       csum_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      err  <= 1'b0;
      wcnt <= '0;
    end else begin
      if (reg_we && hit_ctrl && sel[0])
        run <= wdata[0];
      if (err_set)
        err <= 1'b1;
      else if (reg_we && hit_status && sel[2] && wdata[STATUS_ERR_BIT])
        err <= 1'b0;
      if (wr_done && (wcnt != '1))
        wcnt <= wcnt + 1'b1;
    end
  end

`ifdef WB_IMEM_LOADER_CSUM_EN
  logic [31:0] csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      csum <= '0;
    else if (reg_we && hit_csum)
      csum <= '0;
    else if (wr_done)
      csum <= csum + wr_data;
  end

  assign csum_rd = csum;
`else
  logic unused_csum;
  assign unused_csum = &{1'b0, wr_data};
  assign csum_rd = '0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, wdata[31:17], wdata[15:1], sel[3], sel[1]};

  always_comb begin
    rdata = '0;
    if (hit_ctrl) begin
      rdata[0] = run;
    end else if (hit_status) begin
      rdata[WCNT_W-1:0]     = wcnt;
      rdata[STATUS_ERR_BIT] = err;
      rdata[STATUS_RUN_BIT] = run;
    end else if (hit_csum) begin
      rdata = csum_rd;
    end
  end

endmodule

// File: rtl/wb_imem_loader.sv
// rtl/wb_imem_loader.sv - Wishbone loader owning SRAM port 0 while the core is held in reset
// Optional checksum register enabled by WB_IMEM_LOADER_CSUM_EN.
module wb_imem_loader
  import wb_imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          DEPTH        = 256,
  parameter logic [11:0] CTRL_OFFSET  = 12'h800
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_imem_loader_if.slave     wbs,
  output logic                mem_csb,
  output logic                mem_web,
  output logic [3:0]          mem_wmask,
  output logic [7:0]          mem_addr,
  output logic [31:0]         mem_din,
  input  logic [31:0]         mem_dout,
  output logic                core_rst,
  output logic                mem_own
);

  localparam logic [10:0] DEPTH_LIM  = 11'(DEPTH);
  localparam logic [11:0] OFF_CTRL   = CTRL_OFFSET + REG_CTRL;
  localparam logic [11:0] OFF_STATUS = CTRL_OFFSET + REG_STATUS;
  localparam logic [11:0] OFF_CSUM   = CTRL_OFFSET + REG_CSUM;

  state_t      state, state_nxt;
  logic        hit, is_mem, hit_ctrl, hit_status, hit_csum;
  logic        ld_wr, ld_rd, mem_stop, rd_cap, go_ack;
  logic        reg_we, reg_rd, err_set, wr_done;
  logic        run;
  logic [31:0] reg_rdata, wr_masked;

  assign hit        = (wbs.wbs_adr_i[31:12] == BASE_ADDRESS[31:12]);
  assign is_mem     = hit && ({1'b0, wbs.wbs_adr_i[11:2]} < DEPTH_LIM);
  assign hit_ctrl   = hit && (wbs.wbs_adr_i[11:0] == OFF_CTRL);
  assign hit_status = hit && (wbs.wbs_adr_i[11:0] == OFF_STATUS);
  assign hit_csum   = hit && (wbs.wbs_adr_i[11:0] == OFF_CSUM);

  logic unused_adr;
  assign unused_adr = &{1'b0, wbs.wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_wr     = 1'b0;
    ld_rd     = 1'b0;
    mem_stop  = 1'b0;
    rd_cap    = 1'b0;
    go_ack    = 1'b0;
    reg_we    = 1'b0;
    reg_rd    = 1'b0;
    err_set   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i && !wbs.wbs_ack_o) begin
          if (is_mem && !run) begin
            ld_wr     = wbs.wbs_we_i;
            ld_rd     = !wbs.wbs_we_i;
            state_nxt = wbs.wbs_we_i ? ST_WR : ST_RD;
          end else begin
            // SRAM access while the core runs is refused but still acked.
            err_set   = is_mem;
            reg_we    = !is_mem && wbs.wbs_we_i;
            reg_rd    = !is_mem && !wbs.wbs_we_i;
            go_ack    = 1'b1;
            state_nxt = ST_ACK;
          end
        end
      end
      ST_WR: begin
        mem_stop  = 1'b1;
        wr_done   = 1'b1;
        go_ack    = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_RD: begin
        mem_stop  = 1'b1;
        state_nxt = ST_RDW;
      end
      ST_RDW: begin
        rd_cap    = 1'b1;
        go_ack    = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs.wbs_ack_o <= 1'b0;
      wbs.wbs_dat_o <= '0;
      mem_csb       <= 1'b1;
      mem_web       <= 1'b1;
      mem_wmask     <= '0;
      mem_addr      <= '0;
      mem_din       <= '0;
    end else begin
      wbs.wbs_ack_o <= go_ack;
      wbs.wbs_dat_o <= rd_cap ? mem_dout : (reg_rd ? reg_rdata : '0);
      if (ld_wr) begin
        mem_csb   <= 1'b0;
        mem_web   <= 1'b0;
        mem_wmask <= wbs.wbs_sel_i;
        mem_addr  <= wbs.wbs_adr_i[9:2];
        mem_din   <= wbs.wbs_dat_i;
      end else if (ld_rd) begin
        mem_csb   <= 1'b0;
        mem_web   <= 1'b1;
        mem_wmask <= '0;
        mem_addr  <= wbs.wbs_adr_i[9:2];
      end else if (mem_stop) begin
        mem_csb <= 1'b1;
        mem_web <= 1'b1;
      end
    end
  end

  // Checksum sees only the byte lanes actually written.
  assign wr_masked = mem_din & {{8{mem_wmask[3]}}, {8{mem_wmask[2]}},
                                {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};

  wb_imem_loader_regs u_regs (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .reg_we     (reg_we),
    .hit_ctrl   (hit_ctrl),
    .hit_status (hit_status),
    .hit_csum   (hit_csum),
    .wdata      (wbs.wbs_dat_i),
    .sel        (wbs.wbs_sel_i),
    .err_set    (err_set),
    .wr_done    (wr_done),
    .wr_data    (wr_masked),
    .run        (run),
    .rdata      (reg_rdata)
  );

  assign core_rst = !run;
  assign mem_own  = !run;

endmodule

// File: tb/tb_wb_imem_loader.sv
// tb/tb_wb_imem_loader.sv - self-checking bench for wb_imem_loader with SRAM model and read scoreboard
module tb_wb_imem_loader;

  localparam logic [31:0] A_BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = 32'h3000_0800;
  localparam logic [31:0] A_STATUS = 32'h3000_0804;
  localparam logic [31:0] A_CSUM   = 32'h3000_0808;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_csb, mem_web, core_rst, mem_own;
  logic [3:0]  mem_wmask;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  wb_imem_loader_if wbs ();

  wb_imem_loader #(
    .BASE_ADDRESS (A_BASE),
    .DEPTH        (256),
    .CTRL_OFFSET  (12'h800)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (wbs),
    .mem_csb   (mem_csb),
    .mem_web   (mem_web),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .core_rst  (core_rst),
    .mem_own   (mem_own)
  );

  always #5 clk = ~clk;

  logic [31:0] sram   [256];
  logic [31:0] shadow [256];
  logic [31:0] exp_q  [$];
  logic [31:0] exp_csum;
  int          checks = 0;
  int          errors = 0;
  int          csb_cycles = 0;
  int          wr_cycles = 0;
  logic [7:0]  last_addr;
  logic [3:0]  last_wmask;

  always @(posedge clk) begin
    if (!mem_csb) begin
      if (!mem_web) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end else begin
        mem_dout <= sram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (!mem_csb) csb_cycles++;
    if (!mem_csb && !mem_web) begin
      wr_cycles++;
      last_addr  = mem_addr;
      last_wmask = mem_wmask;
    end
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, output logic [31:0] rdata, output int lat,
                         output logic rst_at_ack);
    @(posedge clk); #1;
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
    wbs.wbs_sel_i = sel;  wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = dat;
    lat = 0; rdata = '0; rst_at_ack = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (wbs.wbs_ack_o) begin
        lat = n + 1; rdata = wbs.wbs_dat_o; rst_at_ack = core_rst;
        break;
      end
    end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
  endtask

  // Issues a loader write and keeps the shadow memory and checksum model in step.
  task automatic mem_write(input int idx, input logic [3:0] sel, input logic [31:0] d, output int lat);
    logic [31:0] rd; logic cr;
    wb_xfer(1'b1, sel, A_BASE + 32'(idx * 4), d, rd, lat, cr);
    shadow[idx] = (shadow[idx] & ~lane_mask(sel)) | (d & lane_mask(sel));
    exp_csum = exp_csum + (d & lane_mask(sel));
  endtask

  task automatic test_reset;
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    checks++; if (mem_own !== 1'b1) begin errors++; $display("FAIL reset_mem_own got=%b exp=1", mem_own); end
    checks++; if (mem_csb !== 1'b1) begin errors++; $display("FAIL reset_csb got=%b exp=1", mem_csb); end
    checks++; if (wbs.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wbs.wbs_ack_o); end
    checks++; if (wbs.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", wbs.wbs_dat_o); end
  endtask

  task automatic test_mem_write;
    logic [31:0] rd, ex; int lat, w0; logic cr;
    w0 = wr_cycles;
    mem_write(4, 4'hF, 32'hDEADBEEF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (wr_cycles - w0 !== 1) begin errors++; $display("FAIL wr_pulse got=%0d exp=1", wr_cycles - w0); end
    checks++; if (last_addr !== 8'd4) begin errors++; $display("FAIL wr_addr got=%0d exp=4", last_addr); end
    checks++; if (last_wmask !== 4'hF) begin errors++; $display("FAIL wr_wmask got=%h exp=f", last_wmask); end
    exp_q.push_back(32'h0000_0001);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (lat !== 2) begin errors++; $display("FAIL status_latency got=%0d exp=2", lat); end
    checks++; if (rd !== ex) begin errors++; $display("FAIL status_after_write got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_mem_read;
    logic [31:0] rd, ex; int lat; logic cr;
    exp_q.push_back(shadow[4]);
    wb_xfer(1'b0, 4'hF, A_BASE + 32'h10, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    checks++; if (rd !== ex) begin errors++; $display("FAIL rd_data got=%h exp=%h", rd, ex); end
    @(posedge clk); #1;
    checks++; if (wbs.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b exp=0", wbs.wbs_ack_o); end
    checks++; if (wbs.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL dat_clears got=%h exp=0", wbs.wbs_dat_o); end
  endtask

  task automatic test_partial_write;
    logic [31:0] rd, ex, ec; int lat; logic cr;
    mem_write(0, 4'b0010, 32'h0000_AB00, lat);
    checks++; if (last_wmask !== 4'b0010) begin errors++; $display("FAIL partial_wmask got=%b exp=0010", last_wmask); end
    exp_q.push_back(shadow[0]);
    wb_xfer(1'b0, 4'hF, A_BASE, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL partial_readback got=%h exp=%h", rd, ex); end
`ifdef WB_IMEM_LOADER_CSUM_EN
    ec = exp_csum;
`else
    ec = 32'h0;
`endif
    exp_q.push_back(ec);
    wb_xfer(1'b0, 4'hF, A_CSUM, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL csum_partial got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_run;
    logic [31:0] rd, ex; int lat, c0; logic cr;
    wb_xfer(1'b1, 4'h2, A_CTRL, 32'h1, rd, lat, cr);
    checks++; if (cr !== 1'b1) begin errors++; $display("FAIL ctrl_sel_masked core_rst=%b exp=1", cr); end
    wb_xfer(1'b1, 4'h1, A_CTRL, 32'h1, rd, lat, cr);
    checks++; if (cr !== 1'b0) begin errors++; $display("FAIL run_core_rst_at_ack got=%b exp=0", cr); end
    checks++; if (mem_own !== 1'b0) begin errors++; $display("FAIL run_mem_own got=%b exp=0", mem_own); end
    c0 = csb_cycles;
    wb_xfer(1'b1, 4'hF, A_BASE + 32'h20, 32'h1234_5678, rd, lat, cr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL reject_latency got=%0d exp=2", lat); end
    checks++; if (csb_cycles - c0 !== 0) begin errors++; $display("FAIL reject_csb got=%0d exp=0", csb_cycles - c0); end
    exp_q.push_back(32'h0003_0002);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL status_run_err got=%h exp=%h", rd, ex); end
    wb_xfer(1'b1, 4'h4, A_STATUS, 32'h0001_0000, rd, lat, cr);
    exp_q.push_back(32'h0002_0002);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL status_err_clear got=%h exp=%h", rd, ex); end
    wb_xfer(1'b1, 4'h1, A_CTRL, 32'h0, rd, lat, cr);
    checks++; if (cr !== 1'b1) begin errors++; $display("FAIL halt_core_rst got=%b exp=1", cr); end
  endtask

  task automatic test_unmapped;
    logic [31:0] rd, ex; int lat, c0; logic cr;
    c0 = csb_cycles;
    wb_xfer(1'b1, 4'hF, A_BASE + 32'h400, 32'hFFFF_FFFF, rd, lat, cr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL gap_wr_latency got=%0d exp=2", lat); end
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 4'hF, A_BASE + 32'h400, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL gap_read got=%h exp=%h", rd, ex); end
    checks++; if (csb_cycles - c0 !== 0) begin errors++; $display("FAIL gap_csb got=%0d exp=0", csb_cycles - c0); end
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 4'hF, 32'h4000_0010, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex || lat !== 2) begin errors++; $display("FAIL offbase_read got=%h lat=%0d exp=%h lat=2", rd, lat, ex); end
    exp_q.push_back(32'h0000_0002);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL gap_no_err got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, ex, ec; int lat; logic cr; int idx [6];
    for (int i = 0; i < 6; i++) begin
      idx[i] = $urandom_range(0, 255);
      mem_write(idx[i], 4'($urandom_range(1, 15)), $urandom, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_wr_latency[%0d] got=%0d exp=3", i, lat); end
    end
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(shadow[idx[i]]);
      wb_xfer(1'b0, 4'hF, A_BASE + 32'(idx[i] * 4), '0, rd, lat, cr);
      ex = exp_q.pop_front();
      checks++; if (rd !== ex) begin errors++; $display("FAIL b2b_rd[%0d] idx=%0d got=%h exp=%h", i, idx[i], rd, ex); end
    end
    exp_q.push_back(32'h0000_0008);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL b2b_count got=%h exp=%h", rd, ex); end
`ifdef WB_IMEM_LOADER_CSUM_EN
    ec = exp_csum;
`else
    ec = 32'h0;
`endif
    exp_q.push_back(ec);
    wb_xfer(1'b0, 4'hF, A_CSUM, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL b2b_csum got=%h exp=%h", rd, ex); end
    wb_xfer(1'b1, 4'hF, A_CSUM, '0, rd, lat, cr);
    exp_csum = '0;
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 4'hF, A_CSUM, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL csum_clear got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd, ex; int lat; logic cr;
    @(posedge clk); #1;
    wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
    wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = A_BASE + 32'h10; wbs.wbs_dat_i = 32'h1111_1111;
    @(posedge clk); #1;
    checks++; if (mem_csb !== 1'b0) begin errors++; $display("FAIL midrst_in_wr csb=%b exp=0", mem_csb); end
    rst = 1'b1; #1;
    checks++; if (mem_csb !== 1'b1) begin errors++; $display("FAIL midrst_csb got=%b exp=1", mem_csb); end
    checks++; if (wbs.wbs_ack_o !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0", wbs.wbs_ack_o); end
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL midrst_core_rst got=%b exp=1", core_rst); end
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 4'hF, A_STATUS, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL midrst_status got=%h exp=%h", rd, ex); end
    exp_q.push_back(shadow[4]);
    wb_xfer(1'b0, 4'hF, A_BASE + 32'h10, '0, rd, lat, cr);
    ex = exp_q.pop_front();
    checks++; if (rd !== ex) begin errors++; $display("FAIL midrst_sram_kept got=%h exp=%h", rd, ex); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      shadow[i] = '0;
    end
    exp_csum = '0;
    mem_dout = '0;
    wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
    wbs.wbs_sel_i = '0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_mem_write;
    test_mem_read;
    test_partial_write;
    test_run;
    test_unmapped;
    test_back_to_back;
    test_reset_mid_write;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_imem_loader.md
Name: wb_imem_loader

Overview:
Wishbone slave that owns the instruction-SRAM RW port while the RISC-V core is halted. It loads program words from the management SoC and reads them back. A control register releases the core's reset.
It sits upstream of the 32x256 SRAM macro and the core. It drives SRAM port 0 and the core reset, replacing ad-hoc clock/reset muxing with a clocked handshake.

Parameters:
BASE_ADDRESS, 32'h3000_0000, Wishbone base of the block; bits [31:12] decode the block.
DEPTH, 256, SRAM words; word offsets 0..DEPTH-1 map to SRAM.
CTRL_OFFSET, 12'h800, byte offset of the CTRL register; STATUS is at +4, CSUM at +8.

Ports:
wb_clk_i  in  1  clock; all state on posedge.
wb_rst_i  in  1  reset, asynchronous, active-high.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte lanes.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  single-cycle acknowledge.
wbs_dat_o  out  32  read data.
mem_csb  out  1  SRAM chip select, active-low.
mem_web  out  1  SRAM write enable, active-low.
mem_wmask  out  4  SRAM byte mask.
mem_addr  out  8  SRAM word address.
mem_din  out  32  SRAM write data.
mem_dout  in  32  SRAM read data, valid one clock after the read edge.
core_rst  out  1  core reset, active-high; equals !RUN.
mem_own  out  1  1 = loader owns the SRAM port (equals core_rst).

Behaviour:
- Reset values (asynchronous):
  - wbs_ack_o=0, wbs_dat_o=0
  - mem_csb=1, mem_web=1, mem_wmask=0, mem_addr=0, mem_din=0
  - RUN=0, so core_rst=1 and mem_own=1
  - write count, ERR and CSUM = 0
  - FSM = IDLE
- All mem_* outputs are registered.
- Decode:
  - hit = adr[31:12]==BASE[31:12].
  - mem region = hit and (adr[11:0]>>2) < DEPTH.
  - CTRL / STATUS / CSUM = hit and adr[11:0] equal to CTRL_OFFSET / +4 / +8.
  - Any other address still gets an ack: reads return 0, writes are ignored.
- FSM states: IDLE, WR, RD, RDW, ACK.
  - IDLE: on cyc&stb with !ack, choose one path:
    - Mem write with RUN=0: load mem_* (csb=0, web=0, wmask=sel, addr=adr[9:2], din=dat) → WR.
    - Mem read with RUN=0: csb=0, web=1, wmask=0 → RD.
    - Mem access with RUN=1: no SRAM activity; set ERR sticky; read data 0 → ACK.
    - Register access: perform it → ACK.
  - WR: SRAM write edge occurs. Deassert csb/web. Increment write count (16-bit, saturating at 16'hFFFF) → ACK.
  - RD: deassert csb → RDW.
  - RDW: wbs_dat_o <= mem_dout → ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle → IDLE. wbs_dat_o returns to 0 the cycle after ack.
- Latency from stb to ack:
  - mem write: ack in the 3rd cycle
  - mem read: ack in the 4th cycle
  - register or rejected access: ack in the 2nd cycle
- Registers:
  - CTRL bit0 RUN: read/write, honours sel[0].
  - STATUS: [15:0] write count (RO), [16] ERR (write 1 to clear, sel[2]), [17] RUN (RO).
- Setting RUN=1 takes effect in the ACK cycle: core_rst falls with ack. Clearing RUN re-halts the core and returns the port.
- A bus master that drops stb before ack aborts nothing: the FSM completes and the ack is dropped harmlessly. A master must not start a new request before ack.
- A mid-operation reset forces csb=1 immediately. The SRAM write is lost, and the write count is not incremented.
- An address at offset ≥ DEPTH*4 below CTRL_OFFSET counts as a non-mem hit: reads return 0, writes are ignored, and ERR is not set.

Optional Feature:
- Macro: WB_IMEM_LOADER_CSUM_EN.
- Defined:
  - CSUM register (+8, RO) accumulates a mod-2^32 sum of each completed SRAM write's data. Bytes with sel=0 are zeroed first.
  - The sum is updated in WR; a write to +8 clears it.
- Undefined: +8 reads 0, writes are ignored, and there is no accumulator logic.

Decomposition:
- Package wb_imem_loader_pkg holds:
  - FSM state enum
  - register offset constants (CTRL_OFFSET+0/4/8)
  - STATUS bit indices (ERR=16, RUN=17)
  - WCNT_W=16
- One sub-module, wb_imem_loader_regs, contains CTRL/STATUS/CSUM storage and read mux. The FSM and SRAM drive stay in the top.

Test Plan:
- After reset: core_rst=1, mem_own=1, csb=1.
- Write 32'hDEADBEEF to 0x3000_0010 with sel=4'hF → mem_addr=4, wmask=F, web=0 for one cycle; ack in the 3rd cycle; STATUS[15:0]=1.
- Read 0x3000_0010 (SRAM model returns the stored word) → ack in the 4th cycle with wbs_dat_o=32'hDEADBEEF.
- Write sel=4'b0010 with data 32'h0000_AB00 to 0x3000_0000 → wmask=4'b0010. With CSUM_EN, CSUM = 0xDEADBEEF+0x0000AB00 = 0xDEAE69EF.
- Write CTRL=1 → core_rst falls in the ack cycle. Then a mem write to 0x3000_0020 → no csb pulse, ack in the 2nd cycle, STATUS=0x0003_0002 (RUN, ERR, count 2). Write STATUS with bit16=1 → ERR clears.
- Assert wb_rst_i during WR → csb=1 immediately, no ack, RUN=0, count unchanged at 0.
